// File: rtl/spi_pkg.sv
// SPI master shared definitions.
// FSM state encoding and mode bit positions.
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_XFER  = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_mc_if.sv
// Parallel-side and serial-side bundle of the SPI master.
// master = the SPI engine, slave = the system driving it.
interface spi_master_mc_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4
);
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [DATA_W-1:0] i_TX_DATA;
    logic              i_TX_DV;
    logic [SEL_W-1:0]  i_CS_SEL;
    logic [1:0]        i_MODE;
    logic              o_TX_READY;
    logic [DATA_W-1:0] o_RX_DATA;
    logic              o_RX_DV;
    logic              o_SCLK;
    logic              o_MOSI;
    logic              i_MISO;
    logic [NUM_CS-1:0] o_CS_n;

    modport master (
        input  i_TX_DATA, i_TX_DV, i_CS_SEL, i_MODE, i_MISO,
        output o_TX_READY, o_RX_DATA, o_RX_DV,
        output o_SCLK, o_MOSI, o_CS_n
    );

    modport slave (
        output i_TX_DATA, i_TX_DV, i_CS_SEL, i_MODE, i_MISO,
        input  o_TX_READY, o_RX_DATA, o_RX_DV,
        input  o_SCLK, o_MOSI, o_CS_n
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI master.
// tick marks the last cycle of each half-period; edges only in XFER.
module spi_sclk_gen #(
    parameter int CLKS_PER_HALF = 2,
    parameter int ECW           = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic           xfer,
    output logic           tick,
    output logic           lead_edge,
    output logic           trail_edge,
    output logic [ECW-1:0] edge_cnt
);
    localparam int HW = $clog2(CLKS_PER_HALF);

    logic [HW-1:0] half_cnt;

    assign tick       = run && (half_cnt == HW'(CLKS_PER_HALF - 1));
    assign lead_edge  = tick && xfer && !edge_cnt[0];
    assign trail_edge = tick && xfer && edge_cnt[0];

    // Free-run the half-period counter while busy; count SCLK edges in XFER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            edge_cnt <= '0;
        end else if (!run) begin
            half_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            half_cnt <= tick ? '0 : half_cnt + 1'b1;
            if (xfer && tick)
                edge_cnt <= edge_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master, all four SPI modes.
// One word per request, MSB first, fixed lead/trail CS guard time.
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int NUM_CS        = 4,
    parameter int CLKS_PER_HALF = 2
) (
    input  logic            P_CLK,
    input  logic            reset,
    spi_master_mc_if.master bus
);
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EDGES = 2 * DATA_W;
    localparam int ECW   = $clog2(EDGES + 1);

    state_t            state_q, state_d;
    logic              accept, finish;
    logic              tick, lead_edge, trail_edge, last_edge;
    logic              sample, shift;
    logic [ECW-1:0]    edge_cnt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic              sclk_q, mosi_q, rx_dv_q;

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_CS-1:0] d;
        for (int i = 0; i < NUM_CS; i++)
            d[i] = (int'(sel) != i);
        return d;
    endfunction

    spi_sclk_gen #(
        .CLKS_PER_HALF(CLKS_PER_HALF),
        .ECW          (ECW)
    ) u_sclk_gen (
        .clk       (P_CLK),
        .rst       (reset),
        .run       (state_q != S_IDLE),
        .xfer      (state_q == S_XFER),
        .tick      (tick),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge),
        .edge_cnt  (edge_cnt)
    );

    assign last_edge = trail_edge && (edge_cnt == ECW'(EDGES - 1));
    assign sample    = mode_q[CPHA_BIT] ? trail_edge : lead_edge;
    assign shift     = mode_q[CPHA_BIT] ? lead_edge : trail_edge;

    // State register.
    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state plus accept/finish strobes for the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_TX_DV) begin
                    accept  = 1'b1;
                    state_d = S_LEAD;
                end
            end
            S_LEAD:  if (tick) state_d = S_XFER;
            S_XFER:  if (last_edge) state_d = S_TRAIL;
            S_TRAIL: begin
                if (tick) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the request, run the shift registers, drive the serial pins.
    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset) begin
            mode_q    <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data_q <= '0;
            rx_dv_q   <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            rx_dv_q <= finish;
            if (accept) begin
                mode_q <= bus.i_MODE;
                sclk_q <= bus.i_MODE[CPOL_BIT];
                cs_n_q <= cs_decode(bus.i_CS_SEL);
                rx_sr  <= '0;
                if (!bus.i_MODE[CPHA_BIT]) begin
                    mosi_q <= bus.i_TX_DATA[DATA_W-1];
                    tx_sr  <= bus.i_TX_DATA << 1;
                end else begin
                    mosi_q <= 1'b0;
                    tx_sr  <= bus.i_TX_DATA;
                end
            end
            if (lead_edge || trail_edge)
                sclk_q <= ~sclk_q;
            if (shift) begin
                mosi_q <= tx_sr[DATA_W-1];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (sample)
                rx_sr <= {rx_sr[DATA_W-2:0], bus.i_MISO};
            if (finish) begin
                rx_data_q <= rx_sr;
                cs_n_q    <= '1;
                mosi_q    <= 1'b0;
                sclk_q    <= mode_q[CPOL_BIT];
            end
        end
    end

    assign bus.o_TX_READY = (state_q == S_IDLE);
    assign bus.o_RX_DATA  = rx_data_q;
    assign bus.o_RX_DV    = rx_dv_q;
    assign bus.o_SCLK     = sclk_q;
    assign bus.o_MOSI     = mosi_q;
    assign bus.o_CS_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master_mc.sv
// Randomized bench for spi_master_mc with a behavioural SPI slave.
// Expected values come from SPI protocol rules, not from the RTL.
module tb_spi_master_mc;
    localparam int DATA_W = 8;
    localparam int NUM_CS = 5;
    localparam int CPH    = 2;
    localparam int LAT    = (2 * DATA_W + 2) * CPH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    spi_master_mc_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus ();

    spi_master_mc #(
        .DATA_W       (DATA_W),
        .NUM_CS       (NUM_CS),
        .CLKS_PER_HALF(CPH)
    ) dut (
        .P_CLK(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural slave: counts SCLK edges, captures MOSI, shifts out reply.
    logic       loop = 1'b0;
    logic [7:0] reply = 8'h00;
    logic [7:0] cap = 8'h00;
    logic       cpol_t = 1'b0;
    logic       cpha_t = 1'b0;
    int         nlead = 0;
    int         ntrail = 0;
    logic       sclk_prev = 1'b0;
    logic       ready_prev = 1'b1;
    int         dv_count = 0;
    int         sidx;
    logic       slave_bit;

    always @(negedge clk) begin
        if (ready_prev && !bus.o_TX_READY) begin
            nlead  = 0;
            ntrail = 0;
            cap    = 8'h00;
        end else if (!bus.o_TX_READY && bus.o_SCLK != sclk_prev) begin
            if (bus.o_SCLK != cpol_t) begin
                nlead++;
                if (!cpha_t) cap = {cap[6:0], bus.o_MOSI};
            end else begin
                ntrail++;
                if (cpha_t) cap = {cap[6:0], bus.o_MOSI};
            end
        end
        sclk_prev  = bus.o_SCLK;
        ready_prev = bus.o_TX_READY;
    end

    always @(negedge clk)
        if (!rst && bus.o_RX_DV) dv_count <= dv_count + 1;

    always_comb begin
        sidx = cpha_t ? nlead - 1 : ntrail;
        if (sidx < 0) sidx = 0;
        if (sidx > 7) sidx = 7;
        slave_bit = reply[7 - sidx];
    end

    assign bus.i_MISO = loop ? bus.o_MOSI : slave_bit;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_TX_READY) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_wait", ok, 1);
    endtask

    task automatic wait_dv(output int lat);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_RX_DV) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_xfer(input logic [7:0] d, input logic [2:0] sel,
                           input logic [1:0] mode, input logic lp,
                           input logic [7:0] rep, input logic glitch);
        int          lat;
        logic [7:0]  exp_rx;
        logic [4:0]  exp_cs;
        exp_rx = lp ? d : rep;
        exp_cs = (int'(sel) < NUM_CS) ? ~(5'd1 << sel) : 5'h1f;
        wait_ready();
        bus.i_TX_DATA = d;
        bus.i_CS_SEL  = sel;
        bus.i_MODE    = mode;
        loop   = lp;
        reply  = rep;
        cpol_t = mode[1];
        cpha_t = mode[0];
        bus.i_TX_DV = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        check("ready_low", bus.o_TX_READY, 0);
        check("cs_active", bus.o_CS_n, exp_cs);
        check("sclk_lead", bus.o_SCLK, mode[1]);
        if (!mode[0]) check("mosi_lead", bus.o_MOSI, d[7]);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (glitch && c == 15) begin
                bus.i_TX_DV   = 1'b1;
                bus.i_TX_DATA = 8'hFF;
                bus.i_MODE    = ~mode;
                bus.i_CS_SEL  = sel ^ 3'd1;
            end
            if (glitch && c == 16) bus.i_TX_DV = 1'b0;
            if (c == 10) check("cs_mid", bus.o_CS_n, exp_cs);
            if (bus.o_RX_DV) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, LAT);
        check("rx_data", bus.o_RX_DATA, exp_rx);
        check("cs_done", bus.o_CS_n, 5'h1f);
        check("ready_done", bus.o_TX_READY, 1);
        @(posedge clk);
        @(negedge clk);
        check("rx_dv_pulse", bus.o_RX_DV, 0);
        check("sclk_idle", bus.o_SCLK, mode[1]);
        check("mosi_idle", bus.o_MOSI, 0);
        check("edges", nlead + ntrail, 2 * DATA_W);
        check("slave_cap", cap, d);
        repeat (3) @(negedge clk);
        check("rx_hold", bus.o_RX_DATA, exp_rx);
        check("no_restart", bus.o_TX_READY, 1);
    endtask

    initial begin
        int lat;
        int dv0;
        bus.i_TX_DATA = '0;
        bus.i_TX_DV   = 1'b0;
        bus.i_CS_SEL  = '0;
        bus.i_MODE    = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.o_TX_READY, 1);
        check("rst_rx_dv", bus.o_RX_DV, 0);
        check("rst_rx_data", bus.o_RX_DATA, 0);
        check("rst_sclk", bus.o_SCLK, 0);
        check("rst_mosi", bus.o_MOSI, 0);
        check("rst_cs", bus.o_CS_n, 5'h1f);
        rst = 1'b0;

        do_xfer(8'hAE, 3'd0, 2'd0, 1'b1, 8'h00, 1'b0);
        do_xfer(8'hB5, 3'd2, 2'd3, 1'b0, 8'h3C, 1'b0);
        do_xfer(8'h69, 3'd5, 2'd0, 1'b1, 8'h00, 1'b0);
        do_xfer(8'h81, 3'd4, 2'd1, 1'b0, 8'hC3, 1'b1);

        wait_ready();
        dv0 = dv_count;
        bus.i_TX_DATA = 8'h11;
        bus.i_CS_SEL  = 3'd1;
        bus.i_MODE    = 2'd0;
        loop = 1'b1; cpol_t = 1'b0; cpha_t = 1'b0;
        bus.i_TX_DV = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_TX_DATA = 8'h22;
        wait_dv(lat);
        check("b2b_lat1", lat, LAT);
        check("b2b_rx1", bus.o_RX_DATA, 8'h11);
        check("b2b_gap", bus.o_CS_n, 5'h1f);
        @(posedge clk);
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        check("b2b_restart", bus.o_TX_READY, 0);
        check("b2b_cs2", bus.o_CS_n, 5'h1d);
        wait_dv(lat);
        check("b2b_lat2", lat, LAT);
        check("b2b_rx2", bus.o_RX_DATA, 8'h22);
        repeat (3) @(negedge clk);
        check("b2b_pulses", dv_count - dv0, 2);

        wait_ready();
        bus.i_TX_DATA = 8'h5A;
        bus.i_CS_SEL  = 3'd2;
        bus.i_MODE    = 2'd3;
        loop = 1'b1; cpol_t = 1'b1; cpha_t = 1'b1;
        bus.i_TX_DV = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_sclk", bus.o_SCLK, 1);
        dv0 = dv_count;
        rst = 1'b1;
        #1;
        check("arst_cs", bus.o_CS_n, 5'h1f);
        check("arst_sclk", bus.o_SCLK, 0);
        check("arst_ready", bus.o_TX_READY, 1);
        check("arst_rx_dv", bus.o_RX_DV, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("arst_no_dv", dv_count - dv0, 0);
        do_xfer(8'hC7, 3'd3, 2'd2, 1'b0, 8'h9E, 1'b0);

        for (int i = 0; i < 14; i++)
            do_xfer(8'($urandom), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/spi_master_mc.md
SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 Parameter DATA_W, default 8: bits per transfer word; legal range 4..32.
REQ-002 Parameter NUM_CS, default 4: number of chip selects; legal range 1..16.
REQ-003 Parameter CLKS_PER_HALF, default 2: P_CLK cycles per SCLK half-period; legal minimum 2.
REQ-004 P_CLK  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_TX_DATA  in  DATA_W  word to transmit, MSB first.
REQ-007 i_TX_DV  in  1  transmit request, qualified by o_TX_READY.
REQ-008 i_CS_SEL  in  max(1,clog2(NUM_CS))  target chip-select index.
REQ-009 i_MODE  in  2  SPI mode; bit1=CPOL, bit0=CPHA.
REQ-010 o_TX_READY  out  1  high when a request can be accepted.
REQ-011 o_RX_DATA  out  DATA_W  last received word.
REQ-012 o_RX_DV  out  1  one-cycle strobe when o_RX_DATA updates.
REQ-013 o_SCLK, o_MOSI  out  1 each  serial clock and data out.
REQ-014 i_MISO  in  1  serial data in.
REQ-015 o_CS_n  out  NUM_CS  active-low chip selects, one-hot-low when active.

Function
REQ-016 FSM states: IDLE, LEAD, XFER, TRAIL; o_TX_READY high only in IDLE.
REQ-017 Accept on rising edge with i_TX_DV=1 and o_TX_READY=1: latch i_TX_DATA, i_CS_SEL, i_MODE; enter LEAD; o_TX_READY low from next cycle.
REQ-018 i_TX_DV while o_TX_READY=0 is ignored; i_MODE and i_CS_SEL changes mid-transfer have no effect.
REQ-019 LEAD: selected o_CS_n bit low for CLKS_PER_HALF cycles; o_SCLK=latched CPOL; if CPHA=0, o_MOSI=data MSB throughout LEAD.
REQ-020 XFER: exactly 2*DATA_W SCLK edges, one every CLKS_PER_HALF cycles; o_SCLK idles at CPOL and toggles on each edge.
REQ-021 CPHA=0: sample i_MISO on leading (odd) edges, shift o_MOSI on trailing edges; CPHA=1: shift o_MOSI on leading edges, sample on trailing edges.
REQ-022 TRAIL: CLKS_PER_HALF cycles, o_SCLK=CPOL, CS still low; on its last cycle CS deasserts, o_RX_DATA loads shift register, o_RX_DV pulses 1 cycle, state returns IDLE with o_TX_READY=1 the same cycle.
REQ-023 Latency: o_RX_DV high exactly (2*DATA_W+2)*CLKS_PER_HALF cycles after accept edge (36 for defaults).
REQ-024 Back-to-back: i_TX_DV held high restarts on the first IDLE cycle; CS stays high at least 1 cycle between words.
REQ-025 i_CS_SEL >= NUM_CS: transfer runs normally with all o_CS_n high; o_RX_DV still pulses.
REQ-026 In IDLE, o_SCLK holds last latched CPOL; o_MOSI holds 0.
REQ-027 o_RX_DATA holds its value until the next o_RX_DV.

Reset
REQ-028 Reset asserted: FSM=IDLE, o_TX_READY=1, o_RX_DV=0, o_RX_DATA=0, o_SCLK=0, o_MOSI=0, o_CS_n all 1, latched mode=0, counters 0.
REQ-029 Reset mid-transfer aborts immediately, no o_RX_DV; first request after release starts a clean transfer.

Structure
REQ-030 Shared package spi_pkg holds FSM state encoding and CPOL/CPHA bit-index constants.
REQ-031 Sub-module spi_sclk_gen: half-period counter emitting leading/trailing edge strobes and edge count.

Verification
REQ-032 Mode 0, MOSI looped to MISO, send 0xAE on CS 0 -> o_RX_DATA=0xAE, only o_CS_n[0] low, o_RX_DV at cycle 36.
REQ-033 Mode 3, slave model returns 0x3C, send 0xB5 on CS 2 -> slave captures 0xB5, o_RX_DATA=0x3C, SCLK idles high.
REQ-034 i_TX_DV held high with 0x11 then 0x22 -> two transfers, CS high >= 1 cycle between, two o_RX_DV pulses.
REQ-035 Reset at cycle 10 of a transfer -> all CS high, o_SCLK=0, o_TX_READY=1, no o_RX_DV.
REQ-036 i_CS_SEL=5 with NUM_CS=4 -> all o_CS_n high, o_RX_DV still at cycle 36.
REQ-037 i_TX_DV pulsed mid-transfer with 0xFF -> ignored, first word's o_RX_DATA unaffected, no extra transfer.
